// File: rtl/jtcps_cpsb_regs.sv
// rtl/jtcps_cpsb_regs.sv - CPS-B style register file with stream-configured address map, ID and multiplier
//
// Purpose: NREGS programmable 16-bit registers whose CPU word addresses come
// from a byte-serial configuration stream. Also provides an ID readback word and
// a pipelined unsigned 16x16 multiplier (mult1, mult2 -> rslt1:rslt0).
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   cfg_we, cfg_data   config byte strobe (rising edge) and byte
//   cfg_clr            clears the config store and byte counter
//   cfg_done           all CFGBYTES config bytes received
//   frame_start        one-cycle pulse at start of vblank
//   cs, addr, dsn, din CPU chip select, word address [5:1], byte lanes (active low), write data
//   dout               registered read data
//   regs_flat          active register values, register i at [16i+15:16i]
//
// Optional feature: define JTCPS_REGS_LATCH_EN to double-buffer the registers
// selected by LATCH_MASK; those commit shadow -> active on frame_start.
module jtcps_cpsb_regs #(
    parameter int               NREGS      = 8,
    parameter int               MULT_LAT   = 2,
    parameter logic [NREGS-1:0] LATCH_MASK = {NREGS{1'b1}},
    parameter int               CFGBYTES   = 6 + NREGS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [7:0]          cfg_data,
    input  logic                cfg_clr,
    output logic                cfg_done,
    input  logic                frame_start,
    input  logic                cs,
    input  logic [4:0]          addr,
    input  logic [1:0]          dsn,
    input  logic [15:0]         din,
    output logic [15:0]         dout,
    output logic [NREGS*16-1:0] regs_flat
);
    localparam int            CW       = $clog2(CFGBYTES + 1);
    localparam logic [CW-1:0] CFG_FULL = CW'(CFGBYTES);

    // Config byte layout
    localparam int B_ID_ADDR = 0;
    localparam int B_ID_VAL  = 1;
    localparam int B_M1      = 2;
    localparam int B_M2      = 3;
    localparam int B_R0      = 4;
    localparam int B_R1      = 5;
    localparam int B_REG0    = 6;

    function automatic logic [15:0] lane_merge(input logic [15:0] old_v,
                                               input logic [15:0] wdata,
                                               input logic [1:0]  lanes_n);
        return {lanes_n[1] ? old_v[15:8] : wdata[15:8],
                lanes_n[0] ? old_v[7:0]  : wdata[7:0]};
    endfunction

    // ------------------------------------------------------------------
    // Config capture. Not touched by rst so a downloaded map survives a
    // CPU reset; only cfg_clr wipes it.
    // ------------------------------------------------------------------
    logic [7:0]    r_cfg [CFGBYTES];
    logic [CW-1:0] r_cfg_cnt;
    logic          r_cfg_we;
    logic          w_cfg_edge;

    assign w_cfg_edge = cfg_we & ~r_cfg_we;
    assign cfg_done   = (r_cfg_cnt == CFG_FULL);

    always_ff @(posedge clk) begin
        if (rst) r_cfg_we <= 1'b0;
        else     r_cfg_we <= cfg_we;
    end

    always_ff @(posedge clk) begin
        if (cfg_clr) begin
            r_cfg_cnt <= '0;
            for (int i = 0; i < CFGBYTES; i++) r_cfg[i] <= 8'h00;
        end else if (w_cfg_edge && !cfg_done) begin
            r_cfg_cnt <= r_cfg_cnt + CW'(1);
            for (int i = 0; i < CFGBYTES; i++) begin
                if (r_cfg_cnt == CW'(i)) r_cfg[i] <= cfg_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Address decode: bit7 of an address byte disables the entry, and the
    // whole map is dead until the config stream is complete.
    // ------------------------------------------------------------------
    logic             w_hit_id, w_hit_m1, w_hit_m2, w_hit_r0, w_hit_r1;
    logic [NREGS-1:0] w_hit_reg;

    assign w_hit_id = cfg_done & ~r_cfg[B_ID_ADDR][7] & (r_cfg[B_ID_ADDR][5:1] == addr);
    assign w_hit_m1 = cfg_done & ~r_cfg[B_M1][7]      & (r_cfg[B_M1][5:1] == addr);
    assign w_hit_m2 = cfg_done & ~r_cfg[B_M2][7]      & (r_cfg[B_M2][5:1] == addr);
    assign w_hit_r0 = cfg_done & ~r_cfg[B_R0][7]      & (r_cfg[B_R0][5:1] == addr);
    assign w_hit_r1 = cfg_done & ~r_cfg[B_R1][7]      & (r_cfg[B_R1][5:1] == addr);

    always_comb begin
        w_hit_reg = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_hit_reg[i] = cfg_done & ~r_cfg[B_REG0+i][7] & (r_cfg[B_REG0+i][5:1] == addr);
        end
    end

    // ------------------------------------------------------------------
    // CPU writes: every matching entry takes the enabled byte lanes.
    // ------------------------------------------------------------------
    logic        w_wr;
    logic [15:0] r_shadow [NREGS];
    logic [15:0] r_mult1, r_mult2;
    logic [15:0] w_mult1_nx, w_mult2_nx;

    assign w_wr = cs & (dsn != 2'b11);

    always_comb begin
        w_mult1_nx = r_mult1;
        w_mult2_nx = r_mult2;
        if (w_wr && w_hit_m1) w_mult1_nx = lane_merge(r_mult1, din, dsn);
        if (w_wr && w_hit_m2) w_mult2_nx = lane_merge(r_mult2, din, dsn);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mult1 <= 16'h0000;
            r_mult2 <= 16'h0000;
            for (int i = 0; i < NREGS; i++) r_shadow[i] <= 16'h0000;
        end else begin
            r_mult1 <= w_mult1_nx;
            r_mult2 <= w_mult2_nx;
            for (int i = 0; i < NREGS; i++) begin
                if (w_wr && w_hit_reg[i]) r_shadow[i] <= lane_merge(r_shadow[i], din, dsn);
            end
        end
    end

    // ------------------------------------------------------------------
    // Multiplier. The first stage multiplies the post-write operand values,
    // so the multiplier input register doubles as pipeline stage 1 and a
    // write becomes visible in rslt exactly MULT_LAT cycles later.
    // ------------------------------------------------------------------
    logic [31:0] r_pipe [MULT_LAT];
    logic [31:0] w_rslt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MULT_LAT; i++) r_pipe[i] <= 32'h0;
        end else begin
            r_pipe[0] <= 32'(w_mult1_nx) * 32'(w_mult2_nx);
            for (int i = 1; i < MULT_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign w_rslt = r_pipe[MULT_LAT-1];

    // ------------------------------------------------------------------
    // Read mux, fixed priority: ID, mult1, mult2, rslt0, rslt1, reg 0..N-1.
    // ------------------------------------------------------------------
    logic [15:0] w_rd;

    always_comb begin
        w_rd = 16'hffff;
        if (addr != 5'h1f) begin
            if (w_hit_id)      w_rd = {4'h0, r_cfg[B_ID_VAL][7:4], 4'h0, r_cfg[B_ID_VAL][3:0]};
            else if (w_hit_m1) w_rd = r_mult1;
            else if (w_hit_m2) w_rd = r_mult2;
            else if (w_hit_r0) w_rd = w_rslt[15:0];
            else if (w_hit_r1) w_rd = w_rslt[31:16];
            else begin
                // Walk downwards so the lowest-numbered matching register wins
                for (int i = NREGS - 1; i >= 0; i--) begin
                    if (w_hit_reg[i]) w_rd = r_shadow[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)     dout <= 16'hffff;
        else if (cs) dout <= w_rd;
    end

    // ------------------------------------------------------------------
    // Active copies
    // ------------------------------------------------------------------
`ifdef JTCPS_REGS_LATCH_EN
    logic [15:0] r_active [NREGS];

    // Commit uses the pre-write shadow, so a write landing with frame_start
    // waits for the following frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_active[i] <= 16'h0000;
        end else if (frame_start) begin
            for (int i = 0; i < NREGS; i++) begin
                if (LATCH_MASK[i]) r_active[i] <= r_shadow[i];
            end
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NREGS; i++) begin
            regs_flat[16*i +: 16] = LATCH_MASK[i] ? r_active[i] : r_shadow[i];
        end
    end
`else
    logic w_unused_latch;
    assign w_unused_latch = ^{frame_start, LATCH_MASK};

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NREGS; i++) begin
            regs_flat[16*i +: 16] = r_shadow[i];
        end
    end
`endif

endmodule

// File: tb/tb_jtcps_cpsb_regs.sv
// tb/tb_jtcps_cpsb_regs.sv - self-checking bench for jtcps_cpsb_regs
module tb_jtcps_cpsb_regs;
    localparam int               NREGS    = 8;
    localparam int               MULT_LAT = 3;
    localparam int               CFGBYTES = 6 + NREGS;
    localparam int               W        = NREGS * 16;
    localparam logic [NREGS-1:0] LMASK    = 8'hB7;

`ifdef JTCPS_REGS_LATCH_EN
    localparam logic [15:0] R2_HOLD = 16'h0011;
`else
    localparam logic [15:0] R2_HOLD = 16'h00F0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_we = 1'b0;
    logic [7:0]   cfg_data = 8'h00;
    logic         cfg_clr = 1'b1;
    logic         cfg_done;
    logic         frame_start = 1'b0;
    logic         cs = 1'b0;
    logic [4:0]   addr = 5'h00;
    logic [1:0]   dsn = 2'b11;
    logic [15:0]  din = 16'h0000;
    logic [15:0]  dout;
    logic [W-1:0] regs_flat;

    always #5 clk = ~clk;

    jtcps_cpsb_regs #(
        .NREGS      (NREGS),
        .MULT_LAT   (MULT_LAT),
        .LATCH_MASK (LMASK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_data    (cfg_data),
        .cfg_clr     (cfg_clr),
        .cfg_done    (cfg_done),
        .frame_start (frame_start),
        .cs          (cs),
        .addr        (addr),
        .dsn         (dsn),
        .din         (din),
        .dout        (dout),
        .regs_flat   (regs_flat)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: byte list, register values, product history queue
    // ------------------------------------------------------------------
    logic [7:0]  m_cfg [CFGBYTES];
    int          m_cnt = 0;
    logic        m_weq = 1'b0;
    logic [15:0] m_sh  [NREGS];
    logic [15:0] m_act [NREGS];
    logic [15:0] m_m1 = 16'h0, m_m2 = 16'h0, m_dout = 16'hffff;
    logic [31:0] m_hist [$];   // front = product visible to the CPU now

    function automatic logic [15:0] m_read(input logic [4:0] a);
        logic [31:0] r;
        if (m_cnt != CFGBYTES || a == 5'h1f) return 16'hffff;
        r = m_hist[0];
        // Byte order of the config stream is also the read priority order
        for (int k = 0; k < CFGBYTES; k++) begin
            if (k == 1) continue;
            if (!m_cfg[k][7] && m_cfg[k][5:1] == a) begin
                case (k)
                    0:       return {4'h0, m_cfg[1][7:4], 4'h0, m_cfg[1][3:0]};
                    2:       return m_m1;
                    3:       return m_m2;
                    4:       return r[15:0];
                    5:       return r[31:16];
                    default: return m_sh[k-6];
                endcase
            end
        end
        return 16'hffff;
    endfunction

    function automatic logic [15:0] m_lanes(input logic [15:0] o);
        logic [15:0] v = o;
        if (!dsn[1]) v[15:8] = din[15:8];
        if (!dsn[0]) v[7:0]  = din[7:0];
        return v;
    endfunction

    function automatic logic [W-1:0] m_flat();
        logic [W-1:0] f = '0;
        for (int i = 0; i < NREGS; i++) begin
`ifdef JTCPS_REGS_LATCH_EN
            f[16*i +: 16] = LMASK[i] ? m_act[i] : m_sh[i];
`else
            f[16*i +: 16] = m_sh[i];
`endif
        end
        return f;
    endfunction

    function automatic void m_step();
        logic [15:0] sh_old [NREGS];
        logic        rise;
        sh_old = m_sh;
        rise   = cfg_we && !m_weq;
        if (rst) begin
            m_dout = 16'hffff;
            m_m1 = 16'h0;
            m_m2 = 16'h0;
            for (int i = 0; i < NREGS; i++) begin
                m_sh[i] = 16'h0;
                m_act[i] = 16'h0;
            end
            for (int i = 0; i < MULT_LAT; i++) m_hist[i] = 32'h0;
        end else begin
            if (cs) m_dout = m_read(addr);
            if (cs && dsn != 2'b11 && m_cnt == CFGBYTES) begin
                for (int k = 2; k < CFGBYTES; k++) begin
                    if (k == 4 || k == 5) continue;
                    if (!m_cfg[k][7] && m_cfg[k][5:1] == addr) begin
                        if (k == 2)      m_m1 = m_lanes(m_m1);
                        else if (k == 3) m_m2 = m_lanes(m_m2);
                        else             m_sh[k-6] = m_lanes(m_sh[k-6]);
                    end
                end
            end
            if (frame_start) begin
                for (int i = 0; i < NREGS; i++) if (LMASK[i]) m_act[i] = sh_old[i];
            end
            m_hist.push_back(32'(m_m1) * 32'(m_m2));
            void'(m_hist.pop_front());
        end
        if (cfg_clr) begin
            for (int k = 0; k < CFGBYTES; k++) m_cfg[k] = 8'h00;
            m_cnt = 0;
        end else if (rise && m_cnt < CFGBYTES) begin
            m_cfg[m_cnt] = cfg_data;
            m_cnt++;
        end
        m_weq = rst ? 1'b0 : cfg_we;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change after the falling edge, outputs are
    // compared on the falling edge after each rising edge.
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        m_step();
        @(negedge clk);
        chk("dout_model", W'(dout), W'(m_dout));
        chk("cfg_done_model", W'(cfg_done), W'(m_cnt == CFGBYTES));
        chk("regs_flat_model", regs_flat, m_flat());
    endtask

    task automatic cpu(input logic c, input logic [4:0] a, input logic [1:0] n,
                       input logic [15:0] d, input logic fs);
        cs = c; addr = a; dsn = n; din = d; frame_start = fs;
        cyc();
        cs = 1'b0; dsn = 2'b11; frame_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic r);
        cfg_data = b; cfg_we = 1'b1; rst = r;
        cyc();
        cfg_we = 1'b0; rst = 1'b0;
        cyc();
    endtask

    task automatic clear_cfg();
        cfg_clr = 1'b1;
        cyc();
        cfg_clr = 1'b0;
    endtask

    typedef struct {
        logic        cs;
        logic [4:0]  a;
        logic [1:0]  n;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;

    localparam int NV = 11;
    vec_t tbl [NV];

    initial begin
        for (int k = 0; k < CFGBYTES; k++) m_cfg[k] = 8'h00;
        for (int i = 0; i < NREGS; i++) begin
            m_sh[i] = 16'h0;
            m_act[i] = 16'h0;
        end
        for (int i = 0; i < MULT_LAT; i++) m_hist.push_back(32'h0);

        // Config 1 map: ID at 0x19, regs at 0x13+i, mult/rslt disabled
        tbl[0]  = '{1'b1, 5'h19, 2'b11, 16'h0000, 16'h0004};
        tbl[1]  = '{1'b1, 5'h13, 2'b10, 16'hA5C3, 16'h0000};
        tbl[2]  = '{1'b1, 5'h13, 2'b01, 16'h1234, 16'h00C3};
        tbl[3]  = '{1'b1, 5'h13, 2'b11, 16'h0000, 16'h12C3};
        tbl[4]  = '{1'b1, 5'h1f, 2'b11, 16'h0000, 16'hffff};
        tbl[5]  = '{1'b1, 5'h1f, 2'b00, 16'h5555, 16'hffff};
        tbl[6]  = '{1'b1, 5'h13, 2'b11, 16'h0000, 16'h12C3};
        tbl[7]  = '{1'b1, 5'h14, 2'b11, 16'h0000, 16'h0000};
        tbl[8]  = '{1'b0, 5'h13, 2'b11, 16'h0000, 16'h0000};
        tbl[9]  = '{1'b1, 5'h01, 2'b00, 16'hBEEF, 16'hffff};
        tbl[10] = '{1'b1, 5'h01, 2'b11, 16'h0000, 16'hffff};

        // Reset state
        rst = 1'b1; cfg_clr = 1'b1;
        cyc();
        chk("reset_dout", W'(dout), W'(16'hffff));
        chk("reset_cfg_done", W'(cfg_done), W'(1'b0));
        chk("reset_regs", regs_flat, '0);
        rst = 1'b0; cfg_clr = 1'b0;
        cyc();

        // Config stream
        send_byte(8'h32, 1'b0);
        send_byte(8'h04, 1'b0);
        for (int k = 0; k < 4; k++) send_byte(8'hff, 1'b0);
        for (int i = 0; i < NREGS - 1; i++) send_byte(8'h26 + 8'(2*i), 1'b0);
        chk("cfg_done_13", W'(cfg_done), W'(1'b0));
        send_byte(8'h26 + 8'(2*(NREGS-1)), 1'b0);
        chk("cfg_done_14", W'(cfg_done), W'(1'b1));
        send_byte(8'h02, 1'b0);
        chk("cfg_done_15", W'(cfg_done), W'(1'b1));

        // Table: ID read, byte lanes, unmapped/disabled, hold
        for (int i = 0; i < NV; i++) begin
            cpu(tbl[i].cs, tbl[i].a, tbl[i].n, tbl[i].d, 1'b0);
            chk($sformatf("tbl%0d_dout", i), W'(dout), W'(tbl[i].exp));
        end

        // Latching of register 2 (address 0x15)
        cpu(1'b1, 5'h15, 2'b00, 16'h0011, 1'b0);
        cpu(1'b0, 5'h00, 2'b11, 16'h0000, 1'b1);
        chk("latch_commit", W'(regs_flat[47:32]), W'(16'h0011));
        cpu(1'b1, 5'h15, 2'b00, 16'h00F0, 1'b1);
        chk("latch_same_cycle", W'(regs_flat[47:32]), W'(R2_HOLD));
        cpu(1'b1, 5'h15, 2'b11, 16'h0000, 1'b0);
        chk("latch_cpu_read", W'(dout), W'(16'h00F0));
        chk("latch_hold", W'(regs_flat[47:32]), W'(R2_HOLD));
        cpu(1'b0, 5'h00, 2'b11, 16'h0000, 1'b1);
        chk("latch_next_frame", W'(regs_flat[47:32]), W'(16'h00F0));

        // Config 2: mult1 0x01, mult2 0x02, rslt0 0x03, rslt1 0x04
        clear_cfg();
        chk("clr_cfg_done", W'(cfg_done), W'(1'b0));
        cpu(1'b1, 5'h19, 2'b11, 16'h0000, 1'b0);
        chk("clr_read_id", W'(dout), W'(16'hffff));
        send_byte(8'h32, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h06, 1'b0);
        send_byte(8'h08, 1'b0);
        for (int i = 0; i < NREGS; i++) send_byte(8'h26 + 8'(2*i), 1'b0);

        // Multiplier latency
        cpu(1'b1, 5'h01, 2'b00, 16'h0002, 1'b0);
        cpu(1'b1, 5'h02, 2'b00, 16'h0005, 1'b0);
        for (int i = 0; i < 4; i++) cyc();
        cpu(1'b1, 5'h03, 2'b11, 16'h0000, 1'b0);
        chk("mult_prior", W'(dout), W'(16'h000A));
        cpu(1'b1, 5'h01, 2'b00, 16'hFFFF, 1'b0);
        cpu(1'b1, 5'h02, 2'b00, 16'h0003, 1'b0);
        cpu(1'b1, 5'h03, 2'b11, 16'h0000, 1'b0);
        chk("mult_c1_rslt0", W'(dout), W'(16'h000A));
        cpu(1'b1, 5'h04, 2'b11, 16'h0000, 1'b0);
        chk("mult_c2_rslt1", W'(dout), W'(16'h0004));
        cpu(1'b1, 5'h03, 2'b11, 16'h0000, 1'b0);
        chk("mult_c3_rslt0", W'(dout), W'(16'hFFFD));
        cpu(1'b1, 5'h04, 2'b11, 16'h0000, 1'b0);
        chk("mult_c4_rslt1", W'(dout), W'(16'h0002));

        // Resets
        cpu(1'b1, 5'h13, 2'b00, 16'h7777, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_cfg_done", W'(cfg_done), W'(1'b1));
        chk("rst_dout", W'(dout), W'(16'hffff));
        chk("rst_regs_flat", regs_flat, '0);
        cpu(1'b1, 5'h13, 2'b11, 16'h0000, 1'b0);
        chk("rst_read_reg0", W'(dout), W'(16'h0000));
        cpu(1'b1, 5'h01, 2'b11, 16'h0000, 1'b0);
        chk("rst_read_mult1", W'(dout), W'(16'h0000));
        clear_cfg();
        chk("clr2_cfg_done", W'(cfg_done), W'(1'b0));
        cpu(1'b1, 5'h13, 2'b11, 16'h0000, 1'b0);
        chk("clr2_read_reg0", W'(dout), W'(16'hffff));
        cpu(1'b1, 5'h19, 2'b11, 16'h0000, 1'b0);
        chk("clr2_read_id", W'(dout), W'(16'hffff));

        // Randomized rounds against the model
        for (int round = 0; round < 4; round++) begin
            clear_cfg();
            for (int k = 0; k < CFGBYTES + 2; k++) begin
                logic [7:0] b;
                if (k == 1) b = 8'($urandom);
                else b = {($urandom_range(0, 7) == 0), 1'($urandom),
                          5'($urandom_range(0, 11)), 1'($urandom)};
                send_byte(b, ($urandom_range(0, 9) == 0));
            end
            for (int c = 0; c < 400; c++) begin
                cs          = ($urandom_range(0, 9) < 7);
                addr        = ($urandom_range(0, 9) < 7) ? m_cfg[$urandom_range(0, CFGBYTES-1)][5:1]
                                                         : 5'($urandom);
                dsn         = 2'($urandom);
                din         = 16'($urandom);
                frame_start = ($urandom_range(0, 5) == 0);
                rst         = ($urandom_range(0, 99) == 0);
                cfg_we      = 1'($urandom);
                cfg_data    = 8'($urandom);
                cyc();
            end
            cs = 1'b0; dsn = 2'b11; frame_start = 1'b0; rst = 1'b0; cfg_we = 1'b0;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
